// File: rtl/jk_excitation_driver_pkg.sv
// Shared types and helpers for the JK excitation driver.
// FSM state encoding, jk_excite(), default sizing constants.
package jk_excitation_driver_pkg;

    localparam int WIDTH_DEF = 4;
    localparam int DEPTH_DEF = 4;
    localparam int CNT_W_DEF = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DRIVE = 2'd1,
        CHECK = 2'd2
    } state_t;

    // Returns {j,k} that moves one JK lane from q to t.
    // Don't-cares resolve to 0, so j=k=1 (toggle) is never produced.
    function automatic logic [1:0] jk_excite(input logic q, input logic t);
        return {~q & t, q & ~t};
    endfunction

endpackage

// File: rtl/jk_excitation_driver_sync_fifo.sv
// Synchronous FIFO for target vectors, no read bypass.
// Ports: clk, reset_n (async low), push/din, pop/dout, full, empty.
module jk_excitation_driver_sync_fifo #(
    parameter int WIDTH = 4,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             push,
    input  logic [WIDTH-1:0] din,
    input  logic             pop,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wptr;
    logic [AW:0]      rptr;
    logic             do_push;
    logic             do_pop;

    // Extra pointer bit distinguishes full from empty.
    assign empty   = (wptr == rptr);
    assign full    = (wptr[AW] != rptr[AW]) &&
                     (wptr[AW-1:0] == rptr[AW-1:0]);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign dout    = mem[rptr[AW-1:0]];

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wptr <= '0;
            rptr <= '0;
        end else begin
            if (do_push) wptr <= wptr + 1'b1;
            if (do_pop)  rptr <= rptr + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wptr[AW-1:0]] <= din;
    end

endmodule

// File: rtl/jk_excitation_driver.sv
// Drives j/k for a bank of JK lanes from buffered target vectors and
// checks the fed-back Q one cycle after the update.
// Ports: clk, reset_n (async low); in_valid/in_target/in_ready stream;
// q_fb lane feedback; j/k lane drive; busy, done, mismatch status;
// err_clr, err_sticky, err_count (saturating) error tracking.
import jk_excitation_driver_pkg::*;

module jk_excitation_driver #(
    parameter int WIDTH = WIDTH_DEF,
    parameter int DEPTH = DEPTH_DEF,
    parameter int CNT_W = CNT_W_DEF
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] in_target,
    output logic             in_ready,
    input  logic [WIDTH-1:0] q_fb,
    output logic [WIDTH-1:0] j,
    output logic [WIDTH-1:0] k,
    output logic             busy,
    output logic             done,
    output logic             mismatch,
    input  logic             err_clr,
    output logic             err_sticky,
    output logic [CNT_W-1:0] err_count
);

    state_t           state;
    state_t           state_nxt;
    logic             pop;
    logic             fifo_full;
    logic             fifo_empty;
    logic [WIDTH-1:0] fifo_dout;
    logic [WIDTH-1:0] target_q;
    logic [WIDTH-1:0] j_nxt;
    logic [WIDTH-1:0] k_nxt;
    logic             miss_now;

    assign in_ready = !fifo_full;
    assign busy     = (state != IDLE) || !fifo_empty;
    assign miss_now = (state == CHECK) && (q_fb != target_q);

    jk_excitation_driver_sync_fifo #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .reset_n (reset_n),
        .push    (in_valid && in_ready),
        .din     (in_target),
        .pop     (pop),
        .dout    (fifo_dout),
        .full    (fifo_full),
        .empty   (fifo_empty)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state <= IDLE;
        else          state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        pop       = 1'b0;
        unique case (state)
            IDLE: begin
                if (!fifo_empty) begin
                    pop       = 1'b1;
                    state_nxt = DRIVE;
                end
            end
            DRIVE:   state_nxt = CHECK;
            CHECK:   state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        j_nxt = '0;
        k_nxt = '0;
        for (int i = 0; i < WIDTH; i++) begin
            {j_nxt[i], k_nxt[i]} = jk_excite(q_fb[i], fifo_dout[i]);
        end
    end

    // j/k are live only for the cycle after a pop; zero otherwise.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            j        <= '0;
            k        <= '0;
            target_q <= '0;
            done     <= 1'b0;
            mismatch <= 1'b0;
        end else begin
            j        <= '0;
            k        <= '0;
            done     <= 1'b0;
            mismatch <= 1'b0;
            if (pop) begin
                j        <= j_nxt;
                k        <= k_nxt;
                target_q <= fifo_dout;
            end
            if (state == CHECK) begin
                done     <= 1'b1;
                mismatch <= miss_now;
            end
        end
    end

    // A mismatch on the same edge as err_clr restarts the count at 1.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            err_sticky <= 1'b0;
            err_count  <= '0;
        end else if (miss_now) begin
            err_sticky <= 1'b1;
            if (err_clr)
                err_count <= {{(CNT_W-1){1'b0}}, 1'b1};
            else if (err_count != {CNT_W{1'b1}})
                err_count <= err_count + 1'b1;
        end else if (err_clr) begin
            err_sticky <= 1'b0;
            err_count  <= '0;
        end
    end

endmodule

// File: tb/tb_jk_excitation_driver.sv
// Bench for jk_excitation_driver: modelled JK lanes plus a
// target scoreboard checked against directed and random stimulus.
module tb_jk_excitation_driver;

    logic       clk = 1'b0;
    logic       reset_n;
    logic       in_valid;
    logic [3:0] in_target;
    logic       in_ready;
    logic [3:0] q_fb;
    logic [3:0] j;
    logic [3:0] k;
    logic       busy;
    logic       done;
    logic       mismatch;
    logic       err_clr;
    logic       err_sticky;
    logic [7:0] err_count;

    logic [3:0] lane_q;
    logic       stuck0;
    logic [3:0] smask;

    int         checks = 0;
    int         errors = 0;
    int         cyc = 0;
    logic       clr_seen = 1'b0;

    logic [3:0] exp_q [$];
    logic [3:0] stim [$];
    int         done_cyc [$];
    logic [3:0] cur_obs = '0;
    int         m_cnt = 0;
    logic       m_sticky = 1'b0;
    logic       saw_full;

    assign smask = {3'b000, stuck0};
    assign q_fb  = lane_q & ~smask;

    always #5 clk = ~clk;

    jk_excitation_driver dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .in_valid   (in_valid),
        .in_target  (in_target),
        .in_ready   (in_ready),
        .q_fb       (q_fb),
        .j          (j),
        .k          (k),
        .busy       (busy),
        .done       (done),
        .mismatch   (mismatch),
        .err_clr    (err_clr),
        .err_sticky (err_sticky),
        .err_count  (err_count)
    );

    // JK lanes, reset together with the driver.
    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) lane_q <= '0;
        else begin
            for (int b = 0; b < 4; b++) begin
                case ({j[b], k[b]})
                    2'b10:   lane_q[b] <= 1'b1;
                    2'b01:   lane_q[b] <= 1'b0;
                    2'b11:   lane_q[b] <= ~lane_q[b];
                    default: lane_q[b] <= lane_q[b];
                endcase
            end
        end
    end

    always @(posedge clk) begin
        cyc      <= cyc + 1;
        clr_seen <= err_clr;
    end

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] want);
        checks++;
        assert (obs === want) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, want);
        end
    endtask

    // Scoreboard: the oldest unfinished target is the one in flight.
    always begin : mon
        logic [3:0] t;
        logic [3:0] o;
        logic       mis_now;
        @(negedge clk);
        #1;
        if (!reset_n) begin
            exp_q.delete();
            cur_obs  = '0;
            m_cnt    = 0;
            m_sticky = 1'b0;
        end else begin
            chk("jk_toggle", 32'(j & k), 0);
            chk("done_spurious", 32'(done && exp_q.size() == 0), 0);
            chk("mismatch_nodone", 32'(mismatch & ~done), 0);
            if ((j | k) != 4'd0 && exp_q.size() > 0) begin
                chk("mon_j", 32'(j), 32'(~cur_obs & exp_q[0]));
                chk("mon_k", 32'(k), 32'(cur_obs & ~exp_q[0]));
            end
            mis_now = 1'b0;
            if (done && exp_q.size() > 0) begin
                t = exp_q.pop_front();
                o = t & ~smask;
                chk("mon_q", 32'(q_fb), 32'(o));
                chk("mon_mismatch", 32'(mismatch), 32'(o != t));
                mis_now = (o != t);
                cur_obs = o;
                done_cyc.push_back(cyc);
            end
            if (mis_now) begin
                m_cnt    = clr_seen ? 1 : (m_cnt == 255 ? 255 : m_cnt + 1);
                m_sticky = 1'b1;
            end else if (clr_seen) begin
                m_cnt    = 0;
                m_sticky = 1'b0;
            end
            chk("mon_err_count", 32'(err_count), m_cnt);
            chk("mon_err_sticky", 32'(err_sticky), 32'(m_sticky));
        end
    end

    // One target from idle with fixed timing: push P0, pop P1, E1 P2, E2 P3.
    task automatic apply_dir(input logic [3:0] t, input logic [3:0] ej,
                             input logic [3:0] ek, input logic em,
                             input logic clr);
        @(negedge clk);
        in_valid  = 1'b1;
        in_target = t;
        chk("dir_ready", 32'(in_ready), 1);
        exp_q.push_back(t);
        @(negedge clk);
        in_valid = 1'b0;
        @(negedge clk); #2;
        chk("dir_j", 32'(j), 32'(ej));
        chk("dir_k", 32'(k), 32'(ek));
        chk("dir_done_early", 32'(done), 0);
        @(negedge clk); #2;
        chk("dir_j_off", 32'(j | k), 0);
        chk("dir_done_e1", 32'(done), 0);
        if (clr) err_clr = 1'b1;
        @(negedge clk); #2;
        err_clr = 1'b0;
        chk("dir_done", 32'(done), 1);
        chk("dir_mismatch", 32'(mismatch), 32'(em));
        chk("dir_q", 32'(q_fb), 32'(t & ~smask));
        @(negedge clk); #2;
        chk("dir_done_pulse", 32'(done), 0);
    endtask

    task automatic push_stream();
        int i = 0;
        int guard = 0;
        saw_full = 1'b0;
        while (i < stim.size() && guard < 5000) begin
            @(negedge clk); #2;
            in_valid  = 1'b1;
            in_target = stim[i];
            if (in_ready) begin
                exp_q.push_back(stim[i]);
                i++;
            end else begin
                saw_full = 1'b1;
            end
            guard++;
        end
        chk("stream_accept", i, stim.size());
        @(negedge clk); #2;
        in_valid = 1'b0;
    endtask

    task automatic wait_idle(input int limit);
        int n = 0;
        while (exp_q.size() != 0 && n < limit) begin
            @(negedge clk); #2;
            n++;
        end
        chk("idle_timeout", exp_q.size(), 0);
        @(negedge clk); #2;
        chk("idle_busy", 32'(busy), 0);
    endtask

    initial begin
        reset_n   = 1'b0;
        in_valid  = 1'b0;
        in_target = '0;
        err_clr   = 1'b0;
        stuck0    = 1'b0;
        repeat (2) @(negedge clk);
        #2;
        chk("rst_j", 32'(j), 0);
        chk("rst_k", 32'(k), 0);
        chk("rst_done", 32'(done), 0);
        chk("rst_mismatch", 32'(mismatch), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_err_count", 32'(err_count), 0);
        chk("rst_err_sticky", 32'(err_sticky), 0);
        reset_n = 1'b1;
        @(negedge clk); #2;
        chk("rst_ready", 32'(in_ready), 1);

        apply_dir(4'b1010, 4'b1010, 4'b0000, 1'b0, 1'b0);
        apply_dir(4'b0110, 4'b0100, 4'b1000, 1'b0, 1'b0);

        stim.delete();
        for (int n = 0; n < 8; n++) stim.push_back(4'($urandom));
        done_cyc.delete();
        push_stream();
        wait_idle(200);
        chk("stream_full_seen", 32'(saw_full), 1);
        chk("stream_done_n", done_cyc.size(), 8);
        for (int n = 1; n < done_cyc.size(); n++)
            chk("stream_spacing", done_cyc[n] - done_cyc[n-1], 3);

        stuck0 = 1'b1;
        stim.delete();
        stim.push_back(4'b0001);
        push_stream();
        wait_idle(50);
        chk("stuck_count1", 32'(err_count), 1);
        chk("stuck_sticky", 32'(err_sticky), 1);
        stim.delete();
        for (int n = 0; n < 299; n++) stim.push_back(4'b0001);
        push_stream();
        wait_idle(2000);
        chk("stuck_sat", 32'(err_count), 32'h0ff);
        chk("stuck_sticky2", 32'(err_sticky), 1);

        apply_dir(4'b0001, 4'b0001, 4'b0000, 1'b1, 1'b1);
        chk("clr_race_count", 32'(err_count), 1);
        chk("clr_race_sticky", 32'(err_sticky), 1);
        err_clr = 1'b1;
        @(negedge clk); #2;
        err_clr = 1'b0;
        chk("clr_count", 32'(err_count), 0);
        chk("clr_sticky", 32'(err_sticky), 0);

        stim.delete();
        for (int n = 0; n < 4; n++) stim.push_back(4'($urandom));
        push_stream();
        @(negedge clk); #2;
        chk("pre_rst_busy", 32'(busy), 1);
        reset_n = 1'b0;
        #1;
        chk("mid_rst_j", 32'(j), 0);
        chk("mid_rst_k", 32'(k), 0);
        chk("mid_rst_busy", 32'(busy), 0);
        chk("mid_rst_done", 32'(done), 0);
        repeat (2) @(negedge clk);
        #2;
        stuck0  = 1'b0;
        reset_n = 1'b1;
        repeat (10) @(negedge clk);
        #2;
        chk("post_rst_ready", 32'(in_ready), 1);
        chk("post_rst_busy", 32'(busy), 0);
        chk("post_rst_count", 32'(err_count), 0);

        stim.delete();
        for (int n = 0; n < 12; n++) stim.push_back(4'($urandom));
        push_stream();
        wait_idle(200);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
